// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the fetch/data memory arbiter
// Purpose: FSM state and grant encodings, full byte-enable constant and
//          wait-counter width used across the arbiter files.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam int         CNT_W   = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, response and memory-command bundle of the arbiter
// Purpose: groups the fetch port, the load/store port, the memory macro port
//          and the pipeline stall line.
// Modports: slave  - the arbiter (takes requests and mem_rdata, drives the rest)
//           master - the environment (core stages plus memory macro)
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_read;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_read
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_read
  );
endinterface

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - loadable down-counter timing the memory read latency
// Purpose: loads a latency value, counts down to zero and holds there.
// Ports: i_clk, i_reset (async active-low), i_load, i_value[CNT_W-1:0], o_zero
module arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory between fetch and load/store
// Purpose: samples fetch/data requests when idle, issues one registered memory
//          command, waits LATENCY cycles, returns read data with a one-cycle
//          ready pulse to the granted requester and stalls the pipeline meanwhile.
// Ports: i_clk, i_reset (async active-low), io_bus (mem_arbiter_if.slave)
// Parameter: LATENCY (1..15) cycles from the mem_en cycle to valid mem_rdata.
// Config: MEM_ARB_RR_EN - on a tie the requester not granted last wins;
//         undefined - on a tie data always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input logic          i_clk,
  input logic          i_reset,
  mem_arbiter_if.slave io_bus
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  arb_state_t  r_state, w_next_state;
  gnt_t        r_gnt, w_gnt;
  logic        w_start, w_finish, w_zero;
  logic        r_mem_en, r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic        r_if_ready, r_d_ready;
  logic [31:0] r_if_rdata, r_d_rdata;
  logic        w_addr_lsb_unused;

  // Word-aligned memory: the byte offset of either address never matters.
  assign w_addr_lsb_unused = ^{io_bus.if_addr[1:0], io_bus.d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
  gnt_t r_last_gnt;
`endif

  always_comb begin
    w_gnt = io_bus.d_req ? GNT_D : GNT_IF;
`ifdef MEM_ARB_RR_EN
    if (io_bus.if_req && io_bus.d_req) begin
      w_gnt = (r_last_gnt == GNT_IF) ? GNT_D : GNT_IF;
    end
`endif
  end

  arb_wait_counter u_wait (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_start),
    .i_value (LAT),
    .o_zero  (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ARB_IDLE;
    else          r_state <= w_next_state;
  end

  // DONE spends one cycle ignoring requests: the winner still holds its
  // request during the ready cycle and must not be sampled a second time.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (io_bus.if_req || io_bus.d_req) begin
          w_start      = 1'b1;
          w_next_state = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (w_zero) begin
          w_finish     = 1'b1;
          w_next_state = ARB_DONE;
        end
      end
      ARB_DONE: w_next_state = ARB_IDLE;
      default:  w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_gnt       <= GNT_IF;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ready   <= 1'b0;
      r_d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_gnt  <= GNT_IF;
`endif
    end else begin
      r_mem_en   <= w_start;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      if (w_start) begin
        r_gnt <= w_gnt;
`ifdef MEM_ARB_RR_EN
        r_last_gnt <= w_gnt;
`endif
        if (w_gnt == GNT_D) begin
          r_mem_we    <= io_bus.d_we;
          r_mem_be    <= io_bus.d_be;
          r_mem_addr  <= {io_bus.d_addr[31:2], 2'b00};
          r_mem_wdata <= io_bus.d_wdata;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_be    <= BE_FULL;
          r_mem_addr  <= {io_bus.if_addr[31:2], 2'b00};
          r_mem_wdata <= '0;
        end
      end
      if (w_finish) begin
        if (r_gnt == GNT_D) begin
          r_d_ready <= 1'b1;
          r_d_rdata <= r_mem_we ? 32'h0 : io_bus.mem_rdata;
        end else begin
          r_if_ready <= 1'b1;
          r_if_rdata <= io_bus.mem_rdata;
        end
      end
    end
  end

  assign io_bus.mem_en     = r_mem_en;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_be     = r_mem_be;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_wdata  = r_mem_wdata;
  assign io_bus.if_ready   = r_if_ready;
  assign io_bus.if_rdata   = r_if_rdata;
  assign io_bus.d_ready    = r_d_ready;
  assign io_bus.d_rdata    = r_d_rdata;
  assign io_bus.stall_read = (io_bus.if_req & ~r_if_ready) | (io_bus.d_req & ~r_d_ready);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (LATENCY 3 and 1)
module tb_mem_arbiter;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   m_last = 1'b0;
  int   cyc = 0;
  int   v0_cyc = -1;
  int   v1_cyc = -1;
  logic [31:0] v0_addr = '0;
  logic [31:0] v1_addr = '0;

  mem_arbiter_if bus ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.LATENCY(LAT)) dut (.i_clk(clk), .i_reset(reset_n), .io_bus(bus));
  mem_arbiter #(.LATENCY(1))   dut1 (.i_clk(clk), .i_reset(reset_n), .io_bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Memory macros: data valid only in the cycle LATENCY after the mem_en cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en)  begin v0_cyc <= cyc + LAT; v0_addr <= bus.mem_addr;  end
    if (bus1.mem_en) begin v1_cyc <= cyc + 1;   v1_addr <= bus1.mem_addr; end
  end
  assign bus.mem_rdata  = (cyc == v0_cyc) ? mem_word(v0_addr) : ~mem_word(v0_addr);
  assign bus1.mem_rdata = (cyc == v1_cyc) ? mem_word(v1_addr) : ~mem_word(v1_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access round on the LATENCY=3 instance; expectations from the timing rules.
  task automatic run_txn(input bit ifr, input bit dr, input bit we, input logic [3:0] be,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         output logic [31:0] first_addr, output bit first_d);
    bit tie, win_d, e_en, e_f, e_d, e_st, gd;
    int f_rdy, d_rdy, kmax;
    logic [31:0] ia_w, da_w;
    logic [68:0] cmd_if, cmd_d;
    tie   = ifr && dr;
    win_d = dr;
`ifdef MEM_ARB_RR_EN
    if (tie) win_d = (m_last == 1'b0);
`endif
    m_last = tie ? !win_d : win_d;
    f_rdy  = !ifr ? -10 : (!win_d ? LAT + 1 : 2 * LAT + 4);
    d_rdy  = !dr  ? -10 : ( win_d ? LAT + 1 : 2 * LAT + 4);
    kmax   = (tie ? 2 * LAT + 4 : LAT + 1) + 2;
    ia_w   = {ia[31:2], 2'b00};
    da_w   = {da[31:2], 2'b00};
    cmd_if = {1'b0, 4'hF, ia_w, 32'h0};
    cmd_d  = {we, be, da_w, wd};
    first_addr = '0;
    first_d    = 1'b0;
    bus.if_req = ifr; bus.if_addr = ia;
    bus.d_req = dr; bus.d_we = we; bus.d_be = be; bus.d_addr = da; bus.d_wdata = wd;
    @(negedge clk);
    for (int k = 0; k <= kmax; k++) begin
      e_en = (k == 0) || (tie && k == LAT + 3);
      e_f  = (k == f_rdy);
      e_d  = (k == d_rdy);
      e_st = (bus.if_req && !e_f) || (bus.d_req && !e_d);
      chk("handshake", 128'({bus.mem_en, bus.if_ready, bus.d_ready, bus.stall_read}),
          128'({e_en, e_f, e_d, e_st}));
      if (e_en) begin
        gd = (k == 0) ? win_d : !win_d;
        chk("command", 128'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
            128'(gd ? cmd_d : cmd_if));
        if (k == 0) first_addr = bus.mem_addr;
      end
      if (e_f) chk("if_rdata", 128'(bus.if_rdata), 128'(mem_word(ia_w)));
      if (e_d) chk("d_rdata", 128'(bus.d_rdata), 128'(we ? 32'h0 : mem_word(da_w)));
      if (k == LAT + 1) first_d = bus.d_ready;
      if (ifr && k == f_rdy + 1) begin bus.if_req = 1'b0; bus.if_addr = ~ia; end
      if (dr && k == d_rdy + 1) begin bus.d_req = 1'b0; bus.d_addr = ~da; bus.d_wdata = ~wd; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          ifr;
    bit          dr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    bit          exp_d_first;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] fa;
    bit fd, e_en, e_rdy;
    int sel;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0,    32'h0,        1'b0, 32'h104};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10,  32'h2002, 32'h0,        1'b1, 32'h2000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10,  32'h2002, 32'h0,        1'b1, 32'h2000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h0,   32'h3000, 32'hDEADBEEF, 1'b1, 32'h3000};
`ifdef MEM_ARB_RR_EN
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10,  32'h2002, 32'h0,        1'b0, 32'h10};
`else
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10,  32'h2002, 32'h0,        1'b1, 32'h2000};
`endif
    vecs[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h204, 32'h0,    32'h0,        1'b0, 32'h204};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10,  32'h2002, 32'h0,        1'b1, 32'h2000};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0,   32'h2ABF, 32'h0,        1'b1, 32'h2ABC};

    reset_n = 1'b0;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_be = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 128'({bus.mem_en, bus.mem_we, bus.mem_be, bus.if_ready, bus.d_ready, bus.stall_read}), 128'(0));
    chk("reset_data", {bus.if_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata}, 128'(0));
    chk("reset_ctl_l1", 128'({bus1.mem_en, bus1.mem_be, bus1.if_ready, bus1.d_ready, bus1.stall_read}), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // LATENCY=1: fetch 0x104, request held through ready, next fetch 0x108.
    bus1.if_req = 1'b1; bus1.if_addr = 32'h104;
    @(negedge clk);
    for (int k = 0; k <= 6; k++) begin
      e_en  = (k == 0) || (k == 4);
      e_rdy = (k == 2) || (k == 6);
      chk("l1_handshake", 128'({bus1.mem_en, bus1.if_ready, bus1.stall_read}), 128'({e_en, e_rdy, !e_rdy}));
      if (k == 0) chk("l1_cmd0", 128'({bus1.mem_we, bus1.mem_be, bus1.mem_addr}), 128'({1'b0, 4'hF, 32'h104}));
      if (k == 4) chk("l1_cmd1", 128'({bus1.mem_we, bus1.mem_be, bus1.mem_addr}), 128'({1'b0, 4'hF, 32'h108}));
      if (k == 2) chk("l1_rdata0", 128'(bus1.if_rdata), 128'(mem_word(32'h104)));
      if (k == 6) chk("l1_rdata1", 128'(bus1.if_rdata), 128'(mem_word(32'h108)));
      if (k == 2) bus1.if_addr = 32'h108;
      if (k == 6) bus1.if_req = 1'b0;
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].ifr, vecs[i].dr, vecs[i].we, vecs[i].be, vecs[i].ia, vecs[i].da,
              vecs[i].wd, fa, fd);
      chk("vec_first_addr", 128'(fa), 128'(vecs[i].exp_addr));
      chk("vec_first_grant", 128'(fd), 128'(vecs[i].exp_d_first));
    end

    // Reset in the middle of a fetch: immediate clear, no ready, late data dropped.
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    @(negedge clk);
    chk("abort_cmd", 128'({bus.mem_en, bus.mem_addr}), 128'({1'b1, 32'h500}));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_clear", 128'({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                                bus.if_ready, bus.d_ready, bus.if_rdata}), 128'(0));
    bus.if_req = 1'b0;
    m_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("abort_no_ready", 128'({bus.if_ready, bus.d_ready, bus.mem_en, bus.if_rdata}), 128'(0));
      @(negedge clk);
    end
    run_txn(1'b1, 1'b0, 1'b0, 4'h0, 32'h600, 32'h0, 32'h0, fa, fd);
    chk("post_reset_addr", 128'(fa), 128'(32'h600));

    for (int i = 0; i < 25; i++) begin
      sel = int'($urandom_range(1, 3));
      run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
              $urandom, $urandom, $urandom, fa, fd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified instruction/data memory between the fetch path and the load/store path of the three-stage RV32I core. It sequences each access through a fixed-latency memory and returns read data to the winning requester. It drives the core-wide `stall_read` so the pipeline freezes while any request is outstanding. It sits between the fetch/execute stages and the memory macro.

## Interface
- `LATENCY`, default 1: number of cycles from the memory command cycle to valid `mem_rdata`. Legal range is 1..15.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high until `if_ready`.
- `if_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `if_ready`  out  1  one-cycle pulse: fetch complete.
- `if_rdata`  out  32  instruction word; valid while `if_ready`=1.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  store byte enables.
- `d_addr`  in  32  data byte address; bits [1:0] ignored.
- `d_wdata`  in  32  store data.
- `d_ready`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  32  load word; valid while `d_ready`=1, 0 for stores.
- `mem_en`  out  1  memory command strobe, exactly one cycle per access.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/4/32/32  registered memory command.
- `mem_rdata`  in  32  memory read data, valid `LATENCY` cycles after the `mem_en` cycle.
- `stall_read`  out  1  combinational: `(if_req & ~if_ready) | (d_req & ~d_ready)`.

## Operation
- FSM states:
  - ARB_IDLE: samples requests. If any is pending, it latches the grant and command, asserts `mem_en` the next cycle, loads the counter with `LATENCY`, and moves to ARB_BUSY.
  - ARB_BUSY: the counter decrements each cycle. At the edge where the counter reaches 0, the block captures `mem_rdata` into the granted `*_rdata`, pulses the granted `*_ready`, and moves to ARB_DONE.
  - ARB_DONE: exactly one cycle. Requests are ignored, because requesters still hold `*_req` in the ready cycle. Next state is ARB_IDLE.
- Arbitration applies on a simultaneous `if_req` and `d_req` in ARB_IDLE; see Configuration for the policy.
- Command formation:
  - `mem_addr` = {addr[31:2], 2'b00}.
  - Fetch commands: `mem_we`=0, `mem_be`=4'hF, `mem_wdata`=0.
  - Data commands: `mem_we`/`mem_be`/`mem_wdata` are passed from `d_*`.
- Store completion: `d_ready` pulses with `d_rdata`=0.
- Protocol violation: a request dropped during ARB_BUSY still completes. The ready pulse is issued and the requester ignores it.
- Reset values: state ARB_IDLE, counter 0, every output 0, last-grant = fetch.
- Reset asserted mid-access: outputs clear immediately (asynchronously) and the access is aborted with no ready pulse. Late `mem_rdata` is never captured.

## Timing
- Request sampled at edge E0:
  - `mem_en` is high in cycle [E0, E0+1).
  - `*_ready` is high in cycle [E0+LATENCY+1, E0+LATENCY+2).
- Minimum spacing between successive `mem_en` pulses is LATENCY+3 cycles: command, LATENCY wait, ready, DONE, then the IDLE sample.
- The losing requester stays stalled. It is granted at the first ARB_IDLE edge after the winner's ARB_DONE.
- `stall_read` is low in the ready cycle of the last outstanding request, so the pipeline advances on that edge.

## Configuration
- `MEM_ARB_RR_EN` defined: on a tie, the requester not granted last wins. Last-grant updates on every grant, tie or not.
- `MEM_ARB_RR_EN` not defined: on a tie, data always wins over fetch. The last-grant register is not built.

## Structure
- The shared package `mem_arb_pkg` holds:
  - state encoding: ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_DONE=2'd2;
  - grant encoding: GNT_IF=1'b0, GNT_D=1'b1;
  - `BE_FULL`=4'hF.
- One sub-module, `arb_wait_counter`: a 4-bit loadable down-counter with `load`, `value`, and a `zero` flag.

## Test plan
- LATENCY=1, fetch only at 0x104: `mem_en` for 1 cycle with `mem_addr`=0x104, then `if_ready` 2 cycles after the sample with `if_rdata`=`mem_rdata`; `stall_read` is high for those 2 cycles.
- Simultaneous fetch 0x10 and load 0x2002, RR off: data is granted first (`mem_addr`=0x2000), fetch follows; a second tie is again won by data.
- Same stimulus with `MEM_ARB_RR_EN`, last grant = data: fetch wins; on the next tie, data wins.
- Store 0xDEADBEEF, be=4'b0011, addr 0x3000, LATENCY=3: `mem_we`=1, `mem_be`=0x3, `d_ready` 4 cycles after the sample with `d_rdata`=0.
- Requests held through the ready cycle: exactly one `mem_en` per access; the next `mem_en` follows LATENCY+3 cycles after the previous one.
- `reset` asserted in ARB_BUSY: outputs go to 0 asynchronously, with no `*_ready`; after release, a new fetch completes normally.
